itof: RTL and testbench

// - Pipelined signed 32-bit integer -> IEEE-754 single conversion; inverse of ftoi in the FPU.
// - Sits beside ftoi in the FPU execute path.
// - Carries the issue tags flag/add alongside the data so writeback can match results to instructions.
// - Rounding: round-to-nearest, ties-to-even (the only mode the FPU supports).

---
 rtl/fpu_pkg.sv | 14 +
 rtl/itof_if.sv | 24 ++
 rtl/itof_lzc32.sv | 26 ++
 rtl/itof.sv | 98 +++++++++
 tb/tb_itof.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/fpu_pkg.sv
// Types and constants shared by the FPU conversion units (itof, ftoi).
package fpu_pkg;

  typedef struct packed {
    logic        s;
    logic [7:0]  e;
    logic [22:0] m;
  } float_t;

  localparam int          EXP_BIAS      = 127;
  localparam int          ITOF_EXP_BASE = 158;
  localparam logic [31:0] FPU_ZERO      = 32'h0000_0000;

endpackage

// File: rtl/itof_if.sv
// Operand/result bundle between the FPU issue logic and the itof converter.
interface itof_if #(
  parameter int TAGW = 5
);
  logic            stall;
  logic [31:0]     x;
  logic            valid_in;
  logic            flagin;
  logic [TAGW-1:0] addin;
  logic [31:0]     y;
  logic            valid_out;
  logic            flagout;
  logic [TAGW-1:0] addout;

  modport master (
    output stall, x, valid_in, flagin, addin,
    input  y, valid_out, flagout, addout
  );

  modport slave (
    input  stall, x, valid_in, flagin, addin,
    output y, valid_out, flagout, addout
  );
endinterface

// File: rtl/itof_lzc32.sv
// Combinational 32-bit leading-zero counter; returns 32 for an all-zero input.
module lzc32 (
  input  logic [31:0] a_i,
  output logic [5:0]  lz_o
);
  logic        z16, z8, z4, z2, z1, zero;
  logic [15:0] v16;
  logic [7:0]  v8;
  logic [3:0]  v4;
  logic [1:0]  v2;

  // Each level halves the window, keeping the upper half unless it is empty.
  always_comb begin
    z16  = ~|a_i[31:16];
    v16  = z16 ? a_i[15:0] : a_i[31:16];
    z8   = ~|v16[15:8];
    v8   = z8 ? v16[7:0] : v16[15:8];
    z4   = ~|v8[7:4];
    v4   = z4 ? v8[3:0] : v8[7:4];
    z2   = ~|v4[3:2];
    v2   = z2 ? v4[1:0] : v4[3:2];
    z1   = ~v2[1];
    zero = z1 & ~v2[0];
    lz_o = zero ? 6'd32 : {1'b0, z16, z8, z4, z2, z1};
  end
endmodule

// File: rtl/itof.sv
// Two-stage signed int32 -> IEEE-754 single converter, round-to-nearest-even,
// with issue tags carried in lockstep with the data.
module itof
  import fpu_pkg::*;
#(
  parameter int TAGW = 5
) (
  input  logic   clk,
  input  logic   rst,
  itof_if.slave  io
);

  function automatic float_t round_pack(input logic        s,
                                        input logic [31:0] mag,
                                        input logic [5:0]  lz);
    logic [31:0] n;
    logic        g, rs, up;
    logic [23:0] m_r;
    float_t      f;
    n   = mag << lz;
    g   = n[7];
    rs  = |n[6:0];
    up  = g & (rs | n[8]);
    m_r = {1'b0, n[30:8]} + {23'd0, up};
    f.s = s;
    // A mantissa carry-out leaves m_r[22:0] at zero, so only the exponent moves.
    f.e = 8'(ITOF_EXP_BASE) - {2'b00, lz} + {7'd0, m_r[23]};
    f.m = m_r[22:0];
    if (mag == 32'd0) f = float_t'(FPU_ZERO);
    return f;
  endfunction

  logic            sign_p0;
  logic [31:0]     mag_p0;
  logic [5:0]      lz_p0;

  logic            vld_p1_q;
  logic            sign_p1_q;
  logic [31:0]     mag_p1_q;
  logic [5:0]      lz_p1_q;
  logic            flag_p1_q;
  logic [TAGW-1:0] add_p1_q;

  float_t          res_p1_d;

  logic            vld_p2_q;
  logic [31:0]     y_p2_q;
  logic            flag_p2_q;
  logic [TAGW-1:0] add_p2_q;

  // Stage 0 -> 1: sign/magnitude split and normalisation shift amount.
  // Magnitude fits 32 bits unsigned: 0 - 0x8000_0000 wraps to 2^31 exactly.
  assign sign_p0 = io.x[31];
  assign mag_p0  = sign_p0 ? (32'd0 - io.x) : io.x;

  lzc32 u_lzc (
    .a_i  (mag_p0),
    .lz_o (lz_p0)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            vld_p1_q <= 1'b0;
    else if (!io.stall) vld_p1_q <= io.valid_in;
  end

  always_ff @(posedge clk) begin
    if (!io.stall) begin
      sign_p1_q <= sign_p0;
      mag_p1_q  <= mag_p0;
      lz_p1_q   <= lz_p0;
      flag_p1_q <= io.flagin;
      add_p1_q  <= io.addin;
    end
  end

  // Stage 1 -> 2: normalise, round, pack into the output registers.
  assign res_p1_d = round_pack(sign_p1_q, mag_p1_q, lz_p1_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p2_q  <= 1'b0;
      y_p2_q    <= FPU_ZERO;
      flag_p2_q <= 1'b0;
      add_p2_q  <= '0;
    end else if (!io.stall) begin
      vld_p2_q  <= vld_p1_q;
      y_p2_q    <= res_p1_d;
      flag_p2_q <= flag_p1_q;
      add_p2_q  <= add_p1_q;
    end
  end

  assign io.y         = y_p2_q;
  assign io.valid_out = vld_p2_q;
  assign io.flagout   = flag_p2_q;
  assign io.addout    = add_p2_q;

endmodule

// File: tb/tb_itof.sv
// Directed + random bench for itof with a queue scoreboard of expected results.
module tb_itof;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  itof_if #(.TAGW(5)) bus ();

  itof #(.TAGW(5)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  typedef struct packed {
    logic [31:0] y;
    logic        f;
    logic [4:0]  a;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   n_push   = 0;
  int   n_out    = 0;
  bit   adv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Independent reference: round the exact double representation down to 24 bits.
  function automatic logic [31:0] model(input logic [31:0] xi);
    real         r;
    logic [63:0] d;
    logic [22:0] keep;
    logic [28:0] rest;
    logic        up;
    logic [23:0] m;
    int          e;
    if (xi == 32'd0) return 32'h0;
    r    = real'($signed(xi));
    d    = $realtobits(r);
    keep = d[51:29];
    rest = d[28:0];
    up   = (rest > 29'h1000_0000) || ((rest == 29'h1000_0000) && keep[0]);
    m    = {1'b0, keep} + {23'd0, up};
    e    = int'(d[62:52]) - 1023 + 127 + int'(m[23]);
    return {d[63], 8'(e), m[22:0]};
  endfunction

  task automatic step(input logic [31:0] xi, input logic v, input logic st,
                      input logic [31:0] e_y);
    @(posedge clk);
    #1;
    bus.x        = xi;
    bus.valid_in = v;
    bus.stall    = st;
    bus.flagin   = 1'($urandom);
    bus.addin    = 5'($urandom);
    if (v && !st) begin
      sb.push_back('{y: e_y, f: bus.flagin, a: bus.addin});
      n_push++;
    end
  endtask

  always @(posedge clk) begin
    adv = !bus.stall && !rst;
    #2;
    if (adv && bus.valid_out) begin
      n_out++;
      if (sb.size() == 0) begin
        n_assert++;
        n_fail++;
        $error("FAIL sb_underflow: observed unexpected y=%h expected no output", bus.y);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("y", bus.y, e.y);
        chk("flagout", {31'd0, bus.flagout}, {31'd0, e.f});
        chk("addout", {27'd0, bus.addout}, {27'd0, e.a});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] fy, fv, ff, fa, xr;
    logic [31:0] edge_x [10];

    rst          = 1'b1;
    bus.stall    = 1'b0;
    bus.x        = '0;
    bus.valid_in = 1'b0;
    bus.flagin   = 1'b0;
    bus.addin    = '0;
    #12;
    chk("rst_y", bus.y, 32'h0);
    chk("rst_valid", {31'd0, bus.valid_out}, 32'd0);
    chk("rst_flag", {31'd0, bus.flagout}, 32'd0);
    chk("rst_add", {27'd0, bus.addout}, 32'd0);
    rst = 1'b0;

    // Latency: nothing after one edge, result after two.
    step(32'd1, 1'b1, 1'b0, 32'h3F80_0000);
    step(32'd0, 1'b0, 1'b0, 32'h0);
    chk("lat1_valid", {31'd0, bus.valid_out}, 32'd0);
    step(32'd0, 1'b0, 1'b0, 32'h0);
    chk("lat2_valid", {31'd0, bus.valid_out}, 32'd1);

    step(32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000);
    step(32'h0000_0001, 1'b1, 1'b0, 32'h3F80_0000);
    step(32'hFFFF_FFFF, 1'b1, 1'b0, 32'hBF80_0000);
    step(32'h8000_0000, 1'b1, 1'b0, 32'hCF00_0000);
    step(32'h7FFF_FFFF, 1'b1, 1'b0, 32'h4F00_0000);
    step(32'd16777217,  1'b1, 1'b0, 32'h4B80_0000);
    step(32'd16777219,  1'b1, 1'b0, 32'h4B80_0002);
    step(32'd16777221,  1'b1, 1'b0, 32'h4B80_0002);
    step(-32'sd16777217, 1'b1, 1'b0, 32'hCB80_0000);

    edge_x = '{32'h00FF_FFFF, 32'h0100_0000, 32'hFF00_0001, 32'h8000_0001,
               32'h7FFF_FFC0, 32'h7FFF_FF80, 32'h4000_0000, 32'h0000_0100,
               32'hFFFF_FF00, 32'h0180_0001};
    foreach (edge_x[i]) step(edge_x[i], 1'b1, 1'b0, model(edge_x[i]));

    for (int i = 0; i < 1000; i++) begin
      xr = (i % 4 == 0) ? ($urandom_range(0, 32'h0200_0000) - 32'h0100_0000) : $urandom;
      step(xr, ($urandom_range(0, 9) != 0), 1'b0, model(xr));
    end
    repeat (3) step(32'h0, 1'b0, 1'b0, 32'h0);
    chk("drain_random", 32'(sb.size()), 32'd0);

    // Stall: A, B enter; stall held for three edges while C waits upstream.
    step(32'd100, 1'b1, 1'b0, model(32'd100));
    step(-32'sd7, 1'b1, 1'b0, model(-32'sd7));
    step(32'd33554433, 1'b1, 1'b1, 32'h0);
    fy = bus.y;
    fv = {31'd0, bus.valid_out};
    ff = {31'd0, bus.flagout};
    fa = {27'd0, bus.addout};
    chk("stall_head_y", fy, model(32'd100));
    for (int k = 0; k < 3; k++) begin
      if (k < 2) step(32'd33554433, 1'b1, 1'b1, 32'h0);
      else       step(32'd33554433, 1'b1, 1'b0, model(32'd33554433));
      chk("stall_y", bus.y, fy);
      chk("stall_valid", {31'd0, bus.valid_out}, fv);
      chk("stall_flag", {31'd0, bus.flagout}, ff);
      chk("stall_add", {27'd0, bus.addout}, fa);
    end
    repeat (3) step(32'h0, 1'b0, 1'b0, 32'h0);
    chk("drain_stall", 32'(sb.size()), 32'd0);

    // Asynchronous reset with one op still in flight.
    step(32'd5, 1'b1, 1'b0, model(32'd5));
    step(32'd6, 1'b1, 1'b0, model(32'd6));
    step(32'h0, 1'b0, 1'b0, 32'h0);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_y", bus.y, 32'h0);
    chk("arst_valid", {31'd0, bus.valid_out}, 32'd0);
    chk("arst_flag", {31'd0, bus.flagout}, 32'd0);
    chk("arst_add", {27'd0, bus.addout}, 32'd0);
    n_push -= sb.size();
    sb.delete();
    @(posedge clk);
    #3;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(32'h0, 1'b0, 1'b0, 32'h0);
      chk("post_rst_valid", {31'd0, bus.valid_out}, 32'd0);
    end
    step(32'hFFFF_FFF6, 1'b1, 1'b0, 32'hC120_0000);
    repeat (3) step(32'h0, 1'b0, 1'b0, 32'h0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("out_count", 32'(n_out), 32'(n_push));
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
